// File: rtl/serial_pkg.sv
// Shared constants and types for the link-cable serial port (SB/SC registers).
package serial_pkg;

  localparam logic [15:0] SB_ADDR        = 16'hFF01;
  localparam logic [15:0] SC_ADDR        = 16'hFF02;
  localparam int          SC_START_BIT   = 7;
  localparam int          SC_CLKSEL_BIT  = 0;
  localparam int          IRQ_SERIAL_BIT = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    EXT
  } xfer_state_t;

  // MSB leaves on sout, the received bit enters at the LSB.
  function automatic logic [7:0] shift_in(input logic [7:0] b, input logic bit_in);
    return {b[6:0], bit_in};
  endfunction

endpackage

// File: rtl/serial_xfer_ctrl_if.sv
// Handshake between the SB/SC register block (master) and the transfer controller (slave).
interface serial_xfer_ctrl_if;

  logic       start;
  logic       abort;
  logic       int_clk;
  logic [7:0] sb_in;
  logic       sin;
  logic       ext_sclk_edge;
  logic       sout;
  logic       sclk_out;
  logic       sb_wr;
  logic [7:0] sb_wdata;
  logic       sc_clr;
  logic       irq;
  logic       busy;

  modport master (
    output start, abort, int_clk, sb_in, sin, ext_sclk_edge,
    input  sout, sclk_out, sb_wr, sb_wdata, sc_clr, irq, busy
  );

  modport slave (
    input  start, abort, int_clk, sb_in, sin, ext_sclk_edge,
    output sout, sclk_out, sb_wr, sb_wdata, sc_clr, irq, busy
  );

endinterface

// File: rtl/serial_bit_timer.sv
// Half-period timer for internal-clock transfers; half_done_o marks the last cycle of each half.
module serial_bit_timer #(
  parameter int HALF = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic run_i,
  output logic half_done_o
);

  localparam int W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [W-1:0] div_cnt_q;

  // Zero is the rest value: the first running cycle reloads HALF-1 and the
  // count then runs down to 1, so each half spans exactly HALF cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else if (clr_i) begin
      div_cnt_q <= '0;
    end else if (run_i) begin
      div_cnt_q <= (div_cnt_q == '0) ? W'(HALF - 1) : div_cnt_q - W'(1);
    end
  end

  assign half_done_o = run_i && (div_cnt_q == W'(1));

endmodule

// File: rtl/serial_xfer_ctrl.sv
// Sequences one 8-bit link-cable transfer: shifts SB out MSB-first, shifts sin in,
// writes each updated byte back and raises the serial interrupt after the eighth bit.
//
//   state | meaning
//   IDLE  | no transfer; sout and sclk_out held high
//   LOW   | internal clock, first half of a bit (sclk_out low, sin sampled at end)
//   HIGH  | internal clock, second half of a bit (shift on last cycle)
//   EXT   | external clock, shift on every ext_sclk_edge
module serial_xfer_ctrl
  import serial_pkg::*;
#(
  parameter int CLK_DIV = 512
) (
  input logic               clk,
  input logic               reset,
  serial_xfer_ctrl_if.slave bus
);

  xfer_state_t state_q;
  logic [7:0]  shift_q;
  logic [7:0]  wdata_q;
  logic [2:0]  bit_cnt_q;
  logic        mode_q;
  logic        sample_q;

  logic        half_done;
  logic        in_bit;
  logic        last_bit;
  logic        shift_evt;
  logic [7:0]  shift_d;

  serial_bit_timer #(
    .HALF(CLK_DIV / 2)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (bus.start | bus.abort),
    .run_i      ((state_q == LOW) || (state_q == HIGH)),
    .half_done_o(half_done)
  );

  assign in_bit   = mode_q ? sample_q : bus.sin;
  assign shift_d  = shift_in(shift_q, in_bit);
  assign last_bit = (bit_cnt_q == 3'd7);

  // A start or abort in the same cycle pre-empts the shift, so no write or irq escapes.
  assign shift_evt = !bus.start && !bus.abort &&
                     (((state_q == HIGH) && half_done) ||
                      ((state_q == EXT) && bus.ext_sclk_edge));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      wdata_q   <= '0;
      bit_cnt_q <= '0;
      mode_q    <= 1'b1;
      sample_q  <= 1'b0;
    end else if (bus.start) begin
      shift_q   <= bus.sb_in;
      bit_cnt_q <= '0;
      mode_q    <= bus.int_clk;
      state_q   <= bus.int_clk ? LOW : EXT;
    end else if (bus.abort) begin
      state_q   <= IDLE;
    end else begin
      case (state_q)
        IDLE: ;
        LOW: begin
          if (half_done) begin
            sample_q <= bus.sin;
            state_q  <= HIGH;
          end
        end
        HIGH, EXT: begin
          if (shift_evt) begin
            shift_q   <= shift_d;
            wdata_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            state_q   <= last_bit ? IDLE : (mode_q ? LOW : EXT);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sout     = (state_q == IDLE) ? 1'b1 : shift_q[7];
  assign bus.sclk_out = (state_q != LOW);
  assign bus.sb_wr    = shift_evt;
  assign bus.sb_wdata = shift_evt ? shift_d : wdata_q;
  assign bus.sc_clr   = shift_evt && last_bit;
  assign bus.irq      = shift_evt && last_bit;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// Directed scoreboard bench for serial_xfer_ctrl with CLK_DIV=4.
module tb_serial_xfer_ctrl;

  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  serial_xfer_ctrl_if bus();

  serial_xfer_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       last;
    int         c;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int irq_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic last, input int c);
    exp_t e;
    e.d = d;
    e.last = last;
    e.c = c;
    sbq.push_back(e);
  endtask

  // Internal-clock writes land on the last HIGH cycle of each bit: t0 + CLK_DIV*(k+1).
  task automatic push_int(input logic [63:0] v, input int t0, input int n);
    for (int k = 0; k < n; k++)
      push_exp(v[63-8*k -: 8], (k == 7), t0 + CLK_DIV * (k + 1));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic at_neg(input int c);
    goto_cyc(c);
    @(negedge clk);
  endtask

  task automatic start_xfer(input logic [7:0] b, input logic ic, input logic ab, output int t0);
    bus.sb_in   = b;
    bus.int_clk = ic;
    bus.start   = 1'b1;
    bus.abort   = ab;
    t0 = cyc;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  // Scoreboard monitor: every write/irq/sc_clr pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (bus.sb_wr || bus.irq || bus.sc_clr)) begin
      if (bus.sb_wr) wr_seen++;
      if (bus.irq) irq_seen++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: sb_wr=%b irq=%b sc_clr=%b wdata=%h at cycle %0d, no pulse expected",
                 bus.sb_wr, bus.irq, bus.sc_clr, bus.sb_wdata, cyc);
      end else begin
        e = sbq.pop_front();
        chk("sb_wr", int'(bus.sb_wr), 1);
        chk("sb_wdata", int'(bus.sb_wdata), int'(e.d));
        chk("irq", int'(bus.irq), int'(e.last));
        chk("sc_clr", int'(bus.sc_clr), int'(e.last));
        chk("pulse_cycle", cyc, e.c);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, base_wr, base_irq;
    logic [7:0] sout_exp;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.int_clk = 1'b0;
    bus.sb_in = 8'h00;
    bus.sin = 1'b0;
    bus.ext_sclk_edge = 1'b0;

    step();
    step();
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_sout", int'(bus.sout), 1);
    chk("rst_sclk", int'(bus.sclk_out), 1);
    chk("rst_sb_wr", int'(bus.sb_wr), 0);
    chk("rst_wdata", int'(bus.sb_wdata), 0);
    chk("rst_irq", int'(bus.irq), 0);
    chk("rst_sc_clr", int'(bus.sc_clr), 0);
    step();
    reset = 1'b0;
    step();

    // Internal transfer of A5 with sin=1
    base_irq = irq_seen;
    bus.sin = 1'b1;
    start_xfer(8'hA5, 1'b1, 1'b0, t0);
    push_int(64'h4B972F5FBF7FFFFF, t0, 8);
    sout_exp = 8'b10100101;
    for (int k = 0; k < 8; k++) begin
      at_neg(t0 + 1 + CLK_DIV * k);
      chk("int_sout", int'(bus.sout), int'(sout_exp[7-k]));
      if (k == 0) begin
        chk("int_busy", int'(bus.busy), 1);
        chk("int_sclk_low", int'(bus.sclk_out), 0);
      end
    end
    at_neg(t0 + 31);
    chk("int_sclk_high", int'(bus.sclk_out), 1);
    at_neg(t0 + 33);
    chk("int_busy_done", int'(bus.busy), 0);
    chk("int_sout_idle", int'(bus.sout), 1);
    chk("int_irq_count", irq_seen - base_irq, 1);

    // External transfer of 3C with sin=0, preceded by stray edges in IDLE
    step();
    bus.sin = 1'b0;
    base_wr = wr_seen;
    bus.ext_sclk_edge = 1'b1; step(); bus.ext_sclk_edge = 1'b0; step();
    bus.ext_sclk_edge = 1'b1; step(); bus.ext_sclk_edge = 1'b0; step();
    chk("idle_edge_no_wr", wr_seen, base_wr);
    base_irq = irq_seen;
    start_xfer(8'h3C, 1'b0, 1'b0, t0);
    for (int k = 0; k < 8; k++) begin
      logic [63:0] v;
      v = 64'h78F0E0C080000000;
      push_exp(v[63-8*k -: 8], (k == 7), t0 + 2 + 3 * k);
    end
    at_neg(t0 + 1);
    chk("ext_busy", int'(bus.busy), 1);
    for (int k = 0; k < 8; k++) begin
      goto_cyc(t0 + 2 + 3 * k);
      bus.ext_sclk_edge = 1'b1;
      step();
      bus.ext_sclk_edge = 1'b0;
    end
    at_neg(t0 + 24);
    chk("ext_busy_done", int'(bus.busy), 0);
    chk("ext_irq_count", irq_seen - base_irq, 1);

    // Abort after three bits of FF with sin=0
    step();
    base_wr = wr_seen;
    base_irq = irq_seen;
    start_xfer(8'hFF, 1'b1, 1'b0, t0);
    push_int(64'hFEFCF80000000000, t0, 3);
    goto_cyc(t0 + 13);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    at_neg(t0 + 14);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_sout", int'(bus.sout), 1);
    at_neg(t0 + 40);
    chk("abort_wr_count", wr_seen - base_wr, 3);
    chk("abort_irq_count", irq_seen - base_irq, 0);

    // Restart: 12 for two bits, then 80, sin=1
    step();
    base_irq = irq_seen;
    bus.sin = 1'b1;
    start_xfer(8'h12, 1'b1, 1'b0, t0);
    push_int(64'h254B000000000000, t0, 2);
    goto_cyc(t0 + 9);
    start_xfer(8'h80, 1'b1, 1'b0, t1);
    push_int(64'h0103070F1F3F7FFF, t1, 8);
    at_neg(t1 + 33);
    chk("restart_busy_done", int'(bus.busy), 0);
    chk("restart_irq_count", irq_seen - base_irq, 1);

    // Asynchronous reset during bit 5 of C3, then a clean transfer of 01
    step();
    bus.sin = 1'b0;
    start_xfer(8'hC3, 1'b1, 1'b0, t0);
    push_int(64'h860C183060000000, t0, 5);
    goto_cyc(t0 + 22);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_sout", int'(bus.sout), 1);
    chk("mid_rst_sclk", int'(bus.sclk_out), 1);
    chk("mid_rst_sb_wr", int'(bus.sb_wr), 0);
    chk("mid_rst_wdata", int'(bus.sb_wdata), 0);
    chk("mid_rst_irq", int'(bus.irq), 0);
    chk("mid_rst_sc_clr", int'(bus.sc_clr), 0);
    step();
    step();
    reset = 1'b0;
    step();
    base_irq = irq_seen;
    start_xfer(8'h01, 1'b1, 1'b0, t0);
    push_int(64'h0204081020408000, t0, 8);
    at_neg(t0 + 33);
    chk("post_rst_busy_done", int'(bus.busy), 0);
    chk("post_rst_irq_count", irq_seen - base_irq, 1);

    // Start and abort together in IDLE: start wins
    step();
    base_irq = irq_seen;
    start_xfer(8'h55, 1'b1, 1'b1, t0);
    push_int(64'hAA54A850A0408000, t0, 8);
    at_neg(t0 + 1);
    chk("start_abort_busy", int'(bus.busy), 1);
    at_neg(t0 + 33);
    chk("start_abort_done", int'(bus.busy), 0);
    chk("start_abort_irq_count", irq_seen - base_irq, 1);

    step();
    chk("sb_queue_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
